system_sysid_checker: RTL and testbench

SYSTEM_SYSID_CHECKER -- requirements
Module: system_sysid_checker

---
 rtl/system_sysid_checker.sv | 186 ++++++++++++++++++
 tb/tb_system_sysid_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/system_sysid_checker.sv
// system_sysid_checker: reads the sysid slave (ID at word 0, timestamp at
// word 1), compares both against the expected build values and reports the
// outcome. Optional auto-start after reset and periodic rechecks.
module system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1393793416,
    parameter int          READ_LATENCY       = 0,
    parameter logic        AUTO_START         = 1'b1,
    parameter logic [31:0] RECHECK_CYCLES     = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  fail_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    // With zero latency the wait states are never entered.
    localparam bit         HAS_WAIT  = (READ_LATENCY != 0);
    localparam logic [1:0] WAIT_LAST = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);
    localparam bit         RECHK_EN  = (RECHECK_CYCLES != 32'd0);

    state_t      state_q, state_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        auto_q, auto_d;
    logic        armed_q, armed_d;
    logic [31:0] rc_q, rc_d;
    logic [31:0] id_buf_q, id_buf_d;
    logic        rv_q, rv_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic [31:0] cid_q, cid_d;
    logic [31:0] cts_q, cts_d;
    logic [7:0]  fc_q, fc_d;

    logic recheck_hit;
    logic trigger;
    logic id_cap;
    logic enter_fin;
    logic id_match;
    logic ts_match;

    // Trigger sources; the recheck fires on the last counted idle cycle.
    always_comb begin
        recheck_hit = RECHK_EN && armed_q && (state_q == IDLE) &&
                      (rc_q == RECHECK_CYCLES - 32'd1);
        trigger     = start || auto_q || recheck_hit;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = 2'd0;
        sysid_read    = 1'b0;
        sysid_address = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (trigger) state_d = RD_ID;
            end
            RD_ID: begin
                sysid_read = 1'b1;
                state_d    = HAS_WAIT ? WAIT_ID : RD_TS;
            end
            WAIT_ID: begin
                if (wcnt_q == WAIT_LAST) state_d = RD_TS;
                else                     wcnt_d  = wcnt_q + 2'd1;
            end
            RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = 1'b1;
                state_d       = HAS_WAIT ? WAIT_TS : FINISH;
            end
            WAIT_TS: begin
                if (wcnt_q == WAIT_LAST) state_d = FINISH;
                else                     wcnt_d  = wcnt_q + 2'd1;
            end
            FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result, bookkeeping and recheck-counter next values.
    always_comb begin
        // ID data is valid in the last cycle of the ID access window; the
        // timestamp window always ends on the edge that enters FINISH.
        id_cap    = ((state_q == RD_ID) && !HAS_WAIT) ||
                    ((state_q == WAIT_ID) && (wcnt_q == WAIT_LAST));
        enter_fin = (state_d == FINISH);
        id_match  = (id_buf_q == EXPECTED_ID);
        ts_match  = (sysid_readdata == EXPECTED_TIMESTAMP);

        id_buf_d = id_cap ? sysid_readdata : id_buf_q;
        rv_d     = rv_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        cid_d    = cid_q;
        cts_d    = cts_q;
        fc_d     = fc_q;
        armed_d  = armed_q;
        auto_d   = auto_q;

        if (state_q == IDLE && trigger) begin
            rv_d   = 1'b0;
            auto_d = 1'b0;
        end
        if (enter_fin) begin
            rv_d    = 1'b1;
            armed_d = 1'b1;
            id_ok_d = id_match;
            ts_ok_d = ts_match;
            cid_d   = id_buf_q;
            cts_d   = sysid_readdata;
            if (!(id_match && ts_match) && fc_q != 8'hFF) fc_d = fc_q + 8'd1;
        end

        // Count idle cycles only once a check has completed; clear on any trigger.
        rc_d = 32'd0;
        if (state_q == IDLE && !trigger && RECHK_EN && armed_q) rc_d = rc_q + 32'd1;
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wcnt_q   <= 2'd0;
            auto_q   <= AUTO_START;
            armed_q  <= 1'b0;
            rc_q     <= 32'd0;
            id_buf_q <= 32'd0;
            rv_q     <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            cid_q    <= 32'd0;
            cts_q    <= 32'd0;
            fc_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            auto_q   <= auto_d;
            armed_q  <= armed_d;
            rc_q     <= rc_d;
            id_buf_q <= id_buf_d;
            rv_q     <= rv_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            cid_q    <= cid_d;
            cts_q    <= cts_d;
            fc_q     <= fc_d;
        end
    end

    assign result_valid = rv_q;
    assign id_ok        = id_ok_q;
    assign ts_ok        = ts_ok_q;
    assign pass         = id_ok_q && ts_ok_q;
    assign captured_id  = cid_q;
    assign captured_ts  = cts_q;
    assign fail_count   = fc_q;

endmodule

// File: tb/tb_system_sysid_checker.sv
// Directed bench for system_sysid_checker: four instances cover zero latency
// with auto-start, latency 2 with failing timestamp and saturation, latency 3
// with mid-check reset, and periodic recheck.
module tb_system_sysid_checker;

    localparam logic [31:0] TS_OK = 32'd1393793416;
    localparam logic [31:0] TS_BAD = 32'h12345678;
    localparam logic [31:0] ID3 = 32'hCAFE0001;
    localparam logic [31:0] GARB = 32'hDEADBEEF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // dut0: L=0 auto-start
    logic rst0, st0, rd0, ad0, busy0, done0, rv0, iok0, tok0, pass0;
    logic [31:0] rdd0, cid0, cts0; logic [7:0] fc0;
    // dut2: L=2, no auto-start, bad timestamp
    logic rst2, st2, rd2, ad2, busy2, done2, rv2, iok2, tok2, pass2;
    logic [31:0] rdd2, cid2, cts2; logic [7:0] fc2;
    // dut3: L=3, auto-start, non-zero ID
    logic rst3, st3, rd3, ad3, busy3, done3, rv3, iok3, tok3, pass3;
    logic [31:0] rdd3, cid3, cts3; logic [7:0] fc3;
    // dutr: L=0, recheck every 10 idle cycles
    logic rstr, str, rdr, adr, busyr, doner, rvr, iokr, tokr, passr;
    logic [31:0] rddr, cidr, ctsr; logic [7:0] fcr;

    // Slave models; data outside the valid cycle is garbage.
    assign rdd0 = rd0 ? (ad0 ? TS_OK : 32'd0) : GARB;
    assign rddr = rdr ? (adr ? TS_OK : 32'd0) : GARB;
    logic [31:0] p2 [2];
    logic [31:0] p3 [3];
    always @(posedge clock) begin
        p2[0] <= rd2 ? (ad2 ? TS_BAD : 32'd0) : GARB;
        p2[1] <= p2[0];
        p3[0] <= rd3 ? (ad3 ? TS_OK : ID3) : GARB;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdd2 = p2[1];
    assign rdd3 = p3[2];

    system_sysid_checker #(.READ_LATENCY(0)) u0 (
        .clock(clock), .reset(rst0), .start(st0), .sysid_address(ad0), .sysid_read(rd0),
        .sysid_readdata(rdd0), .busy(busy0), .done(done0), .result_valid(rv0), .id_ok(iok0),
        .ts_ok(tok0), .pass(pass0), .captured_id(cid0), .captured_ts(cts0), .fail_count(fc0));

    system_sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) u2 (
        .clock(clock), .reset(rst2), .start(st2), .sysid_address(ad2), .sysid_read(rd2),
        .sysid_readdata(rdd2), .busy(busy2), .done(done2), .result_valid(rv2), .id_ok(iok2),
        .ts_ok(tok2), .pass(pass2), .captured_id(cid2), .captured_ts(cts2), .fail_count(fc2));

    system_sysid_checker #(.READ_LATENCY(3), .EXPECTED_ID(ID3)) u3 (
        .clock(clock), .reset(rst3), .start(st3), .sysid_address(ad3), .sysid_read(rd3),
        .sysid_readdata(rdd3), .busy(busy3), .done(done3), .result_valid(rv3), .id_ok(iok3),
        .ts_ok(tok3), .pass(pass3), .captured_id(cid3), .captured_ts(cts3), .fail_count(fc3));

    system_sysid_checker #(.READ_LATENCY(0), .RECHECK_CYCLES(32'd10)) ur (
        .clock(clock), .reset(rstr), .start(str), .sysid_address(adr), .sysid_read(rdr),
        .sysid_readdata(rddr), .busy(busyr), .done(doner), .result_valid(rvr), .id_ok(iokr),
        .ts_ok(tokr), .pass(passr), .captured_id(cidr), .captured_ts(ctsr), .fail_count(fcr));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {start} -> expected {read, address, busy, done, result_valid, pass}
    typedef struct packed {
        logic       st;
        logic [5:0] exp;
    } vec_t;
    vec_t vt [11];

    initial begin
        int n, nd, dk, idk, tsk, nrd, total, gap;
        logic prv;
        rst0 = 1; rst2 = 1; rst3 = 1; rstr = 1;
        st0 = 0; st2 = 0; st3 = 0; str = 0;

        vt[0]  = '{1'b0, 6'b000000};  // start cycle (auto)
        vt[1]  = '{1'b0, 6'b101000};  // RD_ID
        vt[2]  = '{1'b0, 6'b111000};  // RD_TS
        vt[3]  = '{1'b0, 6'b000111};  // FINISH
        vt[4]  = '{1'b0, 6'b000011};
        vt[5]  = '{1'b1, 6'b000011};  // start accepted
        vt[6]  = '{1'b1, 6'b101001};  // start ignored while busy
        vt[7]  = '{1'b1, 6'b111001};
        vt[8]  = '{1'b1, 6'b000111};  // start ignored in FINISH
        vt[9]  = '{1'b0, 6'b000011};
        vt[10] = '{1'b0, 6'b000011};

        tick(); tick();
        chk("rst_u0", {rd0, ad0, busy0, done0, rv0, iok0, tok0, pass0, cid0, cts0, fc0}, 0);
        chk("rst_u2", {rd2, ad2, busy2, done2, rv2, iok2, tok2, pass2, cid2, cts2, fc2}, 0);
        chk("rst_u3", {rd3, ad3, busy3, done3, rv3, iok3, tok3, pass3, cid3, cts3, fc3}, 0);
        chk("rst_ur", {rdr, adr, busyr, doner, rvr, iokr, tokr, passr, cidr, ctsr, fcr}, 0);

        // Zero latency, auto-start, table-driven
        rst0 = 0;
        for (int i = 0; i < 11; i++) begin
            st0 = vt[i].st;
            chk($sformatf("vec%0d", i), {rd0, ad0, busy0, done0, rv0, pass0}, vt[i].exp);
            tick();
        end
        st0 = 0;
        chk("u0_fail_count", fc0, 0);
        chk("u0_captured_ts", cts0, TS_OK);
        chk("u0_ok_bits", {iok0, tok0}, 2'b11);

        // L=2: no auto-start, failing timestamp, repeated start while busy
        rst2 = 0; n = 0;
        for (int k = 0; k < 6; k++) begin
            if (rd2 || busy2) n++;
            tick();
        end
        chk("u2_no_autostart", n, 0);
        st2 = 1; tick();
        nd = 0; dk = -1; idk = -1; tsk = -1; nrd = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done2) begin nd++; dk = k; end
            if (rd2) begin nrd++; if (ad2) tsk = k; else idk = k; end
            st2 = (k <= 6);
            tick();
        end
        chk("u2_done_latency", dk, 7);
        chk("u2_done_count", nd, 1);
        chk("u2_rd_id_cycle", idk, 1);
        chk("u2_rd_ts_cycle", tsk, 4);
        chk("u2_read_count", nrd, 2);
        chk("u2_flags", {iok2, tok2, pass2, rv2}, 4'b1001);
        chk("u2_captured_ts", cts2, TS_BAD);
        chk("u2_captured_id", cid2, 0);
        chk("u2_fail_count1", fc2, 1);

        // Saturation: keep failing until 260 checks completed
        st2 = 1; total = 1;
        for (int k = 0; k < 4000 && total < 260; k++) begin
            if (done2) begin
                total++;
                if (total == 254) chk("u2_fc_254", fc2, 254);
            end
            tick();
        end
        st2 = 0;
        chk("u2_sat_reached", total, 260);
        chk("u2_fc_saturated", fc2, 255);

        // L=3: first check, then reset in WAIT_TS
        rst3 = 0; dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (done3) begin dk = k; break; end
            tick();
        end
        chk("u3_done_latency", dk, 9);
        chk("u3_pass", {pass3, rv3}, 2'b11);
        chk("u3_captured_id", cid3, ID3);
        tick();
        st3 = 1; tick(); st3 = 0;
        repeat (6) tick();
        chk("u3_in_wait_ts", {busy3, rd3, done3}, 3'b100);
        rst3 = 1; tick();
        chk("u3_abort_outputs", {rd3, ad3, busy3, done3, rv3, iok3, tok3, pass3, cid3, cts3, fc3}, 0);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (done3 || rd3) n++;
            tick();
        end
        chk("u3_abort_no_done", n, 0);
        rst3 = 0; dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (done3) begin dk = k; break; end
            tick();
        end
        chk("u3_fresh_latency", dk, 9);
        chk("u3_fresh_pass", {pass3, fc3}, {1'b1, 8'd0});

        // Recheck every 10 idle cycles
        rstr = 0; dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (doner) begin dk = k; break; end
            tick();
        end
        chk("ur_first_done", dk, 3);
        for (int j = 0; j < 2; j++) begin
            gap = -1; prv = rvr;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (rdr && !adr) begin gap = k; break; end
                prv = rvr;
            end
            chk($sformatf("ur_gap%0d", j), gap, 11);
            chk($sformatf("ur_rv_before%0d", j), prv, 1);
            chk($sformatf("ur_rv_drop%0d", j), rvr, 0);
            dk = -1;
            for (int k = 0; k < 10; k++) begin
                if (doner) begin dk = k; break; end
                tick();
            end
            chk($sformatf("ur_done%0d", j), dk, 2);
        end
        // start in the same cycle the recheck expires
        repeat (10) tick();
        chk("ur_idle_before", {rdr, busyr}, 2'b00);
        str = 1; tick(); str = 0;
        chk("ur_combined_read", {rdr, adr}, 2'b10);
        nd = 0; dk = -1; nrd = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (doner) begin nd++; dk = k; end
            if (rdr && !adr) nrd++;
        end
        chk("ur_combined_done", {nd[7:0], dk[7:0]}, {8'd1, 8'd2});
        chk("ur_combined_reads", nrd, 1);
        tick();
        chk("ur_next_recheck", {rdr, adr}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
